// File: rtl/data_cache_dm.sv
// Purpose : direct-mapped, write-through, no-write-allocate data cache between the load/store stage and word memory.
// Latency : load hit zero-wait; load miss = WORDS_PER_LINE memory acks + 1 cycle; store = one memory write, done on its ack.
// Backpr. : core holds req_i and its inputs until ready_o; the memory side stalls the cache by withholding mem_ack_i.
// Ports   : clk_i/rst_n_i clock and async active-low reset; req_i/we_i/addr_i/wdata_i/wstrb_i CPU access;
//           flush_i invalidates all lines (IDLE only); rdata_o/ready_o CPU response; mem_req_o/mem_we_o/mem_addr_o/
//           mem_wdata_o/mem_wstrb_o memory request; mem_rdata_i/mem_ack_i memory response.
// Option  : define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o access counters.
module data_cache_dm #(
   parameter int ADDR_W         = 32,
   parameter int NUM_LINES      = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        wstrb_i,
   input  logic              flush_i,
   output logic [31:0]       rdata_o,
   output logic              ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_wstrb_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int OFF   = $clog2(WORDS_PER_LINE);
   localparam int IDX   = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 2 - OFF - IDX;
   localparam int DEPTH = NUM_LINES * WORDS_PER_LINE;

   typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} state_e;

   state_e                 state_q, state_d;
   logic [OFF-1:0]         cnt_q, cnt_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   logic [31:0]            data_q [DEPTH];
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];

   logic [IDX-1:0]         index;
   logic [TAG_W-1:0]       tag;
   logic [OFF+IDX-1:0]     rd_ptr;   // {index, word}: flat position of the addressed word
   logic                   hit;
   logic                   fill_we;
   logic                   tag_we;
   logic                   merge_we;
   logic                   unused_addr_lsb;

   assign index  = addr_i[2+OFF+IDX-1:2+OFF];
   assign tag    = addr_i[ADDR_W-1:2+OFF+IDX];
   assign rd_ptr = addr_i[2+OFF+IDX-1:2];
   assign hit    = valid_q[index] && (tag_q[index] == tag);
   assign unused_addr_lsb = ^addr_i[1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      fill_we     = 1'b0;
      tag_we      = 1'b0;
      merge_we    = 1'b0;
      ready_o     = 1'b0;
      rdata_o     = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wstrb_o = '0;
      case (state_q)
         IDLE: begin
            // A flush takes the whole cycle; any concurrent request is retried next cycle.
            if (flush_i) begin
               valid_d = '0;
            end else if (req_i) begin
               if (we_i) begin
                  state_d = WRITE;
               end else if (hit) begin
                  ready_o = 1'b1;
                  rdata_o = data_q[rd_ptr];
               end else begin
                  // Line is invalid while refilling so an abandoned refill never looks valid.
                  valid_d[index] = 1'b0;
                  cnt_d          = '0;
                  state_d        = REFILL;
               end
            end
         end
         REFILL: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {tag, index, cnt_q, 2'b00};
            if (mem_ack_i) begin
               fill_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (&cnt_q) begin
                  tag_we         = 1'b1;
                  valid_d[index] = 1'b1;
                  state_d        = RESP;
               end
            end
         end
         RESP: begin
            ready_o = 1'b1;
            rdata_o = we_i ? 32'h0 : data_q[rd_ptr];
            state_d = IDLE;
         end
         WRITE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {addr_i[ADDR_W-1:2], 2'b00};
            mem_wdata_o = wdata_i;
            mem_wstrb_o = wstrb_i;
            if (mem_ack_i) begin
               ready_o  = 1'b1;
               merge_we = hit;   // no-write-allocate: only an already-cached word is updated
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // Data and tag storage carry no reset; the valid bits alone decide what is trusted.
   always_ff @(posedge clk_i) begin
      if (fill_we) begin
         data_q[{index, cnt_q}] <= mem_rdata_i;
      end
      if (tag_we) begin
         tag_q[index] <= tag;
      end
      if (merge_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) begin
               data_q[rd_ptr][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic        accept;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // Every access accepted in IDLE is classified once, by its hit status at acceptance.
   assign accept = (state_q == IDLE) && req_i && !flush_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (accept) begin
         if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_dm.sv
// Purpose : randomized scoreboard bench for data_cache_dm against a flat-memory + tag-table reference model.
// Latency : driver holds each access until ready_o; monitor pops one expected response per ready_o pulse.
// Backpr. : memory responder acks with a configurable probability and an optional ack budget.
module tb_data_cache_dm;

   localparam int AW  = 32;
   localparam int NL  = 64;
   localparam int WPL = 4;
   localparam logic [31:0] LINE_MASK = ~32'(WPL*4-1);

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        req_i, we_i, flush_i;
   logic [31:0] addr_i, wdata_i;
   logic [3:0]  wstrb_i;
   logic [31:0] rdata_o;
   logic        ready_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
   int          mdl_hits, mdl_misses;
`endif

   always #5 clk_i = ~clk_i;

   data_cache_dm #(.ADDR_W(AW), .NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .flush_i(flush_i), .rdata_o(rdata_o), .ready_o(ready_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
      , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
   );

   typedef struct {
      logic [31:0] rdata;
      int          n_rd;
      logic [31:0] rd_base;
      int          n_wr;
      logic [31:0] wr_addr;
      logic [3:0]  wr_strb;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] rd_log [$];
   logic [35:0] wr_log [$];
   logic [31:0] mem     [int unsigned];   // what the memory holds (written by the DUT)
   logic [31:0] ref_mem [int unsigned];   // what a flat memory should hold (written by stimulus)
   bit          ref_valid [NL];
   logic [31:0] ref_tag   [NL];
   int          checks = 0;
   int          errors = 0;
   int          ack_pct = 100;
   int          ack_budget = -1;

   function automatic logic [31:0] init_word(int unsigned wa);
      return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction
   function automatic logic [31:0] rd_mem(int unsigned wa);
      return mem.exists(wa) ? mem[wa] : init_word(wa);
   endfunction
   function automatic logic [31:0] rd_ref(int unsigned wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
   endtask

   // Memory responder: decides each ack half a cycle ahead of the edge that consumes it.
   initial begin
      int unsigned wa;
      logic [31:0] w;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         mem_ack_i   = 1'b0;
         mem_rdata_i = '0;
         if (rst_n_i && mem_req_o && ack_budget != 0 && $urandom_range(1, 100) <= ack_pct) begin
            mem_ack_i = 1'b1;
            if (ack_budget > 0) ack_budget--;
            wa = mem_addr_o >> 2;
            if (mem_we_o) begin
               w = rd_mem(wa);
               for (int b = 0; b < 4; b++) if (mem_wstrb_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
               mem[wa] = w;
               wr_log.push_back({mem_wstrb_o, mem_addr_o});
            end else begin
               mem_rdata_i = rd_mem(wa);
               rd_log.push_back(mem_addr_o);
            end
         end
      end
   end

   // Monitor: each ready_o pulse retires the oldest expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #3;
         if (ready_o) begin
            if (sb.size() == 0) begin
               check("unexpected_ready", 64'(ready_o), 64'd0);
            end else begin
               e = sb.pop_front();
               check("rdata", 64'(rdata_o), 64'(e.rdata));
               check("refill_words", 64'(rd_log.size()), 64'(e.n_rd));
               for (int i = 0; i < rd_log.size(); i++)
                  check("refill_addr", 64'(rd_log[i]), 64'(e.rd_base + 32'(4*i)));
               check("mem_writes", 64'(wr_log.size()), 64'(e.n_wr));
               if (wr_log.size() > 0) check("write_strb_addr", 64'(wr_log[0]), 64'({e.wr_strb, e.wr_addr}));
            end
            rd_log.delete();
            wr_log.delete();
         end
      end
   end

   // Issue one access at a negedge and hold it until ready_o; returns at a negedge.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_t        e;
      int          ix, waited;
      logic [31:0] tg, cur;
      bit          hit;
      ix  = int'((a / (WPL*4)) % NL);
      tg  = a / (WPL*4*NL);
      hit = ref_valid[ix] && ref_tag[ix] == tg;
      e.rdata = '0; e.n_rd = 0; e.rd_base = a & LINE_MASK; e.n_wr = 0; e.wr_addr = a & ~32'h3; e.wr_strb = s;
      if (!w) begin
         e.rdata = rd_ref(a >> 2);
         e.n_rd  = hit ? 0 : WPL;
         ref_valid[ix] = 1'b1;
         ref_tag[ix]   = tg;
      end else begin
         e.n_wr = 1;
         cur = rd_ref(a >> 2);
         for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
         ref_mem[a >> 2] = cur;
      end
`ifdef DCACHE_STATS_EN
      if (hit) mdl_hits++; else mdl_misses++;
`endif
      sb.push_back(e);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; wstrb_i = s;
      waited = 0;
      #3;
      while (!ready_o && waited < 200) begin
         @(negedge clk_i);
         flush_i = ($urandom_range(0, 3) == 0);   // must be ignored outside IDLE
         #3;
         waited++;
      end
      if (!ready_o) begin
         $display("FAIL access_timeout addr=%0h actual=no_ready required=ready", a);
         errors++;
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $fatal(1, "access timeout");
      end
      if (!w && hit) check("zero_wait_hit", 64'(waited), 64'd0);
      if (!w && !hit && ack_pct == 100) check("miss_latency", 64'(waited), 64'(WPL + 1));
      @(negedge clk_i);
      flush_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic flush_cycle(input logic with_req, input logic [31:0] a);
      flush_i = 1'b1; req_i = with_req; we_i = 1'b0; addr_i = a;
      #3;
      check("flush_no_ready", 64'(ready_o), 64'd0);
      @(negedge clk_i);
      flush_i = 1'b0; req_i = 1'b0;
      clear_model();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; flush_i = 1'b0;
      addr_i = '0; wdata_i = '0; wstrb_i = '0;
      clear_model();
`ifdef DCACHE_STATS_EN
      mdl_hits = 0; mdl_misses = 0;
`endif
      for (int i = 0; i < WPL; i++) begin
         mem[(32'h40 >> 2) + i]     = 32'h11 * (i + 1);
         ref_mem[(32'h40 >> 2) + i] = 32'h11 * (i + 1);
      end
      repeat (3) @(negedge clk_i);
      #3;
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_mem_req", 64'(mem_req_o), 64'd0);
      check("reset_rdata", 64'(rdata_o), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // Directed sequence with back-to-back acks.
      access(1'b0, 32'h40, 32'h0, 4'h0);
      access(1'b0, 32'h48, 32'h0, 4'h0);
      access(1'b1, 32'h44, 32'h0000_AB00, 4'b0010);
      access(1'b0, 32'h44, 32'h0, 4'h0);
      access(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
      access(1'b0, 32'h1000, 32'h0, 4'h0);
      flush_cycle(1'b0, 32'h0);
      access(1'b0, 32'h40, 32'h0, 4'h0);
      access(1'b0, 32'h440, 32'h0, 4'h0);
      access(1'b0, 32'h40, 32'h0, 4'h0);
      flush_cycle(1'b1, 32'h40);
      access(1'b0, 32'h40, 32'h0, 4'h0);
      access(1'b1, 32'h48, 32'h1234_5678, 4'h0);
      access(1'b0, 32'h48, 32'h0, 4'h0);

      // Reset in the middle of a refill: only two of four words arrive.
      flush_cycle(1'b0, 32'h0);
      ack_budget = 2;
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
      for (int i = 0; i < 50 && ack_budget != 0; i++) @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      #2;
      check("refill_req_held", 64'(mem_req_o), 64'd1);
      rst_n_i = 1'b0;
      #1;
      check("rst_mem_req_drop", 64'(mem_req_o), 64'd0);
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
`ifdef DCACHE_STATS_EN
      check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
      check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
      mdl_hits = 0; mdl_misses = 0;
`endif
      req_i = 1'b0;
      rd_log.delete();
      wr_log.delete();
      clear_model();
      ack_budget = -1;
      @(negedge clk_i);
      #2;
      rst_n_i = 1'b1;
      @(negedge clk_i);
      access(1'b0, 32'h40, 32'h0, 4'h0);

      // Randomized traffic over a small address pool to force hits, conflicts and partial stores.
      ack_pct = 70;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 14) == 0) begin
            flush_cycle(1'b0, 32'h0);
         end else begin
            access($urandom_range(0, 9) < 3,
                   32'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3)),
                   $urandom, 4'($urandom_range(0, 15)));
         end
      end

      repeat (3) @(negedge clk_i);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
`ifdef DCACHE_STATS_EN
      check("hit_cnt", 64'(hit_cnt), 64'(mdl_hits));
      check("miss_cnt", 64'(miss_cnt), 64'(mdl_misses));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_cache_dm.md
Name: data_cache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the core's load/store stage and a word-wide backing memory.
- Successor to the flat combinational data store. Adds the following:
  - parametrised geometry
  - tag/valid arrays
  - byte-strobe writes
  - a multi-word line refill over a req/ack memory handshake
  - flush
- The core stalls on ready_o.

Parameters:
- ADDR_W, 32, byte-address width on both interfaces.
- NUM_LINES, 64, number of cache lines (power of 2, ≥2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_i  in  1  CPU access request; hold stable with all CPU inputs until ready_o.
- we_i  in  1  1=store, 0=load.
- addr_i  in  ADDR_W  byte address; bits[1:0] ignored.
- wdata_i  in  32  store data, little-endian byte lanes.
- wstrb_i  in  4  store byte enables.
- flush_i  in  1  invalidate all lines.
- rdata_o  out  32  load data, valid when ready_o and !we_i.
- ready_o  out  1  access complete this cycle.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  word-aligned memory address.
- mem_wdata_o  out  32  memory write data.
- mem_wstrb_o  out  4  memory byte enables.
- mem_rdata_i  in  32  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completes current word.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE)
  - IDX = log2(NUM_LINES)
  - word = addr[2+OFF-1:2]
  - index = addr[2+OFF+IDX-1:2+OFF]
  - tag = addr[ADDR_W-1:2+OFF+IDX]
- States: IDLE, REFILL, RESP, WRITE.
- Reset (async, rst_n_i low):
  - state=IDLE, all valid bits=0, refill counter=0.
  - All outputs 0.
  - Data/tag arrays are not cleared.
- IDLE:
  - Hit = valid[index] && tag match. Evaluated combinationally.
  - Load hit: ready_o=1 in the same cycle, rdata_o=line word. Zero-wait.
  - Load miss: clear valid[index] → REFILL, counter=0.
  - Store (hit or miss) → WRITE.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,counter,2'b00}.
  - Each cycle with mem_ack_i: write mem_rdata_i into word[counter], then counter+1.
  - On ack of the last word (counter==WORDS_PER_LINE-1): set tag and valid → RESP. mem_req_o drops the next cycle.
  - Words fill in order 0..N-1 (no critical-word-first).
  - mem_req_o stays high between acks.
- RESP:
  - ready_o=1, rdata_o=refilled word → IDLE.
  - Miss latency = N acks + 1 cycle.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_addr_o=addr_i word-aligned, mem_wdata_o=wdata_i, mem_wstrb_o=wstrb_i.
  - On mem_ack_i: ready_o=1 that cycle → IDLE.
  - If the line hit at the ack cycle, merge the strobed bytes into the cached word; a miss does not allocate.
  - wstrb_i=0: still performs the memory transaction; cache is unchanged.
- ready_o is a single-cycle pulse per access. rdata_o=0 whenever ready_o=0 or we_i=1.
- flush_i:
  - Honoured only in IDLE: all valid bits cleared at the clock edge. A request in the same cycle is not serviced (ready_o=0); it is re-evaluated next cycle and misses.
  - In REFILL, RESP and WRITE, flush_i is ignored.
- Reset mid-REFILL: the line stays invalid and the transaction is abandoned. The memory side must tolerate mem_req_o dropping without an ack.
- mem_ack_i while mem_req_o=0 is ignored.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], reset to 0, wrapping at 2^32.
  - Load hit in IDLE: hit_cnt+1.
  - IDLE→REFILL: miss_cnt+1.
  - Stores: hit_cnt+1 if hit at acceptance, else miss_cnt+1.
  - Flush does not reset the counters.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Default params; after reset, load 0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 on 4 consecutive acks:
  - mem_addr_o=0x40,0x44,0x48,0x4C.
  - Next cycle ready_o=1, rdata_o=0x11.
  - Load 0x48 then returns 0x33 zero-wait with no mem_req_o.
- After the above, store 0x44 wstrb=4'b0010 wdata=0x0000_AB00:
  - One memory write with strobe 0010.
  - ready_o on ack.
  - Load 0x44 hits with 0x0000_AB22.
- Store to uncached 0x1000 → memory write only; subsequent load 0x1000 misses (refill issued).
- Conflict: load 0x40, then 0x440 (same index, different tag), then 0x40 → three refills.
- Flush: load 0x40 (fill), assert flush_i with req_i load 0x40 → ready_o=0 that cycle; next cycle miss and refill.
- Assert rst_n_i low after 2 of 4 acks in REFILL:
  - mem_req_o=0 immediately.
  - Load 0x40 afterwards refills from word 0.
  - With DCACHE_STATS_EN, counters read 0.
